// File: rtl/spi_slave_regs_pkg.sv
// Shared widths, SIZE encoding, FSM state codes and the size mask helper
// for the SPI register responder.
package spi_slave_regs_pkg;

  localparam int unsigned SPI_DWIDTH = 32;
  localparam int unsigned SPI_AWIDTH = 8;

  // Mask helper works on a wide word; callers truncate to their data width.
  localparam int unsigned MASK_W = 64;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } spi_size_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  function automatic logic [MASK_W-1:0] size_mask(input spi_size_t sz);
    logic [MASK_W-1:0] m;
    m = '0;
    case (sz)
      SZ_BYTE: m = MASK_W'(64'h0000_0000_0000_00ff);
      SZ_HALF: m = MASK_W'(64'h0000_0000_0000_ffff);
      SZ_WORD: m = '1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/spi_slave_regs_sync.sv
// Brings the asynchronous SPI pins into the clk domain and turns sclk/ss_n
// into single-cycle edge pulses.
module spi_slave_regs_sync (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic ss_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ss_rise,
  output logic ss_fall,
  output logic mosi_s
);

  logic [2:0] sclk_q;
  logic [2:0] ss_q;
  logic [1:0] mosi_q;

  // ss_n idles high, so its chain resets high to avoid a fake select edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= 3'b000;
      ss_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      ss_q   <= {ss_q[1:0], ss_n};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign ss_rise   = ss_q[1] & ~ss_q[2];
  assign ss_fall   = ~ss_q[1] & ss_q[2];
  assign mosi_s    = mosi_q[1];

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-0 responder: decodes {WR_EN, SIZE, ADDR, DATA} frames MSB first
// and writes or reads a local register bank.
module spi_slave_regs
  import spi_slave_regs_pkg::*;
#(
  parameter int unsigned DWIDTH = spi_slave_regs_pkg::SPI_DWIDTH,
  parameter int unsigned AWIDTH = spi_slave_regs_pkg::SPI_AWIDTH,
  parameter int unsigned NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid,
  output logic              wr_strobe,
  output logic              err
);

  localparam int unsigned CW   = 3 + AWIDTH;
  localparam int unsigned MAXW = (CW > DWIDTH) ? CW : DWIDTH;
  localparam int unsigned BW   = $clog2(MAXW);
  localparam int unsigned IW   = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [BW-1:0] CMD_LAST  = BW'(CW - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DWIDTH - 1);

  logic sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;

  spi_slave_regs_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .ss_n      (ss_n),
    .mosi      (mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ss_rise   (ss_rise),
    .ss_fall   (ss_fall),
    .mosi_s    (mosi_s)
  );

  logic [1:0]        state_q;
  logic [BW-1:0]     bit_cnt_q;
  logic [CW-2:0]     cmd_q;
  logic              wr_en_q;
  spi_size_t         size_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] shreg_q;
  logic [DWIDTH-1:0] rd_word_q;
  logic              commit_q;
  logic              miso_q;
  logic [DWIDTH-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              wr_strobe_q;
  logic              err_q;
  logic [DWIDTH-1:0] regs_q [NREGS];

  // Command decode uses the bit being sampled right now as the LSB.
  logic [CW-1:0]     cmd_word;
  logic              cmd_wr;
  spi_size_t         cmd_size;
  logic [AWIDTH-1:0] cmd_addr;
  logic              cmd_ok;
  logic [DWIDTH-1:0] load_word;

  assign cmd_word = {cmd_q, mosi_s};
  assign cmd_wr   = cmd_word[CW-1];
  assign cmd_size = spi_size_t'(cmd_word[AWIDTH+1:AWIDTH]);
  assign cmd_addr = cmd_word[AWIDTH-1:0];
  assign cmd_ok   = (32'(cmd_addr) < 32'(NREGS)) && (cmd_size != SZ_RSVD);

  always_comb begin
    load_word = '0;
    if (!cmd_wr && cmd_ok) begin
      load_word = regs_q[cmd_addr[IW-1:0]] & DWIDTH'(size_mask(cmd_size));
    end
  end

  logic              frame_ok;
  logic [IW-1:0]     wr_idx;
  logic [DWIDTH-1:0] cur_mask;
  logic [DWIDTH-1:0] merged;

  assign frame_ok = (32'(addr_q) < 32'(NREGS)) && (size_q != SZ_RSVD);
  assign wr_idx   = addr_q[IW-1:0];
  assign cur_mask = DWIDTH'(size_mask(size_q));
  assign merged   = (regs_q[wr_idx] & ~cur_mask) | (shreg_q & cur_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      cmd_q       <= '0;
      wr_en_q     <= 1'b0;
      size_q      <= SZ_BYTE;
      addr_q      <= '0;
      shreg_q     <= '0;
      rd_word_q   <= '0;
      commit_q    <= 1'b0;
      miso_q      <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      wr_strobe_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rd_valid_q  <= 1'b0;
      wr_strobe_q <= 1'b0;
      err_q       <= 1'b0;
      commit_q    <= 1'b0;

      // Commit runs independently of the FSM so a quick deselect cannot cut it.
      if (commit_q) begin
        err_q <= ~frame_ok;
        if (wr_en_q) begin
          wr_strobe_q <= frame_ok;
        end else begin
          rd_valid_q <= 1'b1;
          rd_data_q  <= rd_word_q;
        end
      end

      if (ss_rise) begin
        state_q <= IDLE;
        miso_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (ss_fall) begin
              state_q   <= CMD;
              bit_cnt_q <= '0;
              miso_q    <= 1'b0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              cmd_q     <= cmd_word[CW-2:0];
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == CMD_LAST) begin
                wr_en_q   <= cmd_wr;
                size_q    <= cmd_size;
                addr_q    <= cmd_addr;
                shreg_q   <= load_word;
                rd_word_q <= load_word;
                bit_cnt_q <= '0;
                state_q   <= DATA;
              end
            end
          end
          DATA: begin
            if (sclk_rise) begin
              shreg_q   <= {shreg_q[DWIDTH-2:0], mosi_s};
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == DATA_LAST) begin
                state_q  <= DONE;
                commit_q <= 1'b1;
                miso_q   <= 1'b0;
              end
            end else if (sclk_fall && !wr_en_q) begin
              miso_q <= shreg_q[DWIDTH-1];
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else if (commit_q && wr_en_q && frame_ok) begin
      regs_q[wr_idx] <= merged;
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = (state_q != IDLE);
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign wr_strobe = wr_strobe_q;
  assign err       = err_q;

endmodule
